muxn_rr_reg: RTL and testbench
==============================

Name: muxn_rr_reg

Overview:
- Parametrised successor to the 2:1 gate-level mux: an NCH-channel, WIDTH-bit multiplexer with a registered output slot and a valid/ready output handshake.
- Two selection modes:
  - manual select, which generalises the sel input;
  - round-robin scan across requesting channels.
- Sits between several producer channels and one consumer. Each captured word is tagged with its source channel.

Parameters:
- WIDTH, 8, data bits per channel.
- NCH, 4, number of input channels; legal range 2..16.
- SELW, $clog2(NCH), select/channel-tag width. Derived; never overridden.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- mode  input  1  0 = manual select, 1 = round-robin scan.
- sel  input  SELW  channel index used in manual mode.
- d  input  NCH*WIDTH  packed channel data; channel i is d[i*WIDTH +: WIDTH].
- d_valid  input  NCH  per-channel request.
- d_ack  output  NCH  one-hot pulse marking the channel captured this cycle.
- out_ready  input  1  consumer accepts out_data.
- out_valid  output  1  output slot holds a word.
- out_data  output  WIDTH  registered selected data.
- out_ch  output  SELW  source channel of out_data.
- sel_err  output  1  sticky; set when manual sel >= NCH.

Behaviour:
- Reset (async, on rst_n low): out_valid=0, out_data=0, out_ch=0, sel_err=0, rr pointer=0. d_ack=0 while rst_n is low (d_ack is combinational).
- Slot free condition: free = !out_valid || out_ready.
- Capture happens on a clock edge when free and a grant exists. On capture:
  - out_data <= d[g], out_ch <= g, out_valid <= 1;
  - d_ack[g]=1 combinationally in that cycle.
- Latency: d_valid[g] high in cycle N gives out_valid in cycle N+1.
- Manual mode (mode=0):
  - g = sel when sel < NCH and d_valid[sel]=1; otherwise no grant.
  - sel >= NCH: no grant, and sel_err <= 1. sel_err clears only on reset.
- Scan mode (mode=1):
  - g = first i with d_valid[i]=1, searching ptr, ptr+1, ... wrapping modulo NCH.
  - The search is single-cycle and combinational.
  - On capture, ptr <= (g+1) mod NCH. With no grant, ptr holds.
- Mode switch: takes effect in the same cycle's grant computation. ptr is retained across manual periods. The slot content is unaffected.
- Hold rule: while out_valid && !out_ready, out_data and out_ch are stable and d_ack is 0.
- No grant while free: out_valid <= 0 if out_ready consumed the word; otherwise it holds.
- Back-to-back streaming: out_ready held at 1 with requests present gives one capture per cycle, with no bubbles.
- Simultaneous consume and capture: the new word replaces the old one in the same edge.
- Reset mid-transfer: the word in the slot is discarded and no d_ack is issued.
- Invariants:
  - d_ack is 0 or one-hot (never more than one bit set).
  - d_ack is never asserted when !free.

Decomposition:
- Shared package muxn_pkg holds:
  - NCH_MAX=16;
  - typedef mode_e {MODE_MANUAL=1'b0, MODE_SCAN=1'b1};
  - function rr_next(ptr, nch) for the wrap increment.
- One natural sub-module: rr_arbiter (inputs: req[NCH], ptr; outputs: grant one-hot, grant_idx, any). It is combinational.
- The top module holds the slot register, the pointer and the error flag.

Test Plan:
- Reset/idle: rst_n low for 3 cycles, then release with d_valid=0. Required: out_valid=0, out_data=0, out_ch=0, d_ack=0 for 5 cycles.
- Manual select: mode=0, sel=2, d[2]=8'hA5, d_valid=4'b0100, out_ready=1. Required: d_ack=4'b0100 in cycle N; out_valid=1, out_data=A5, out_ch=2 in cycle N+1.
- Invalid sel: NCH=3, sel=3, d_valid=3'b111. Required: no capture, d_ack=0, sel_err=1 and stays set after sel returns to 0.
- Round-robin fairness: mode=1, d_valid=4'b1111 held, out_ready=1, d[i]=8'h10+i. Required: out_ch sequence 0,1,2,3,0 on consecutive cycles with out_data 10,11,12,13,10.
- Backpressure: slot holds 8'h3C and out_ready=0 for 4 cycles while d_valid=4'b0010. Required: out_data=3C stable and d_ack=0 throughout. When out_ready=1, channel 1 is captured on that edge.
- Reset mid-operation: out_valid=1 with out_ready=0; pulse rst_n low between clock edges. Required: out_valid drops immediately (asynchronously) and ptr returns to 0, so the next scan grants channel 0 first.

Source files
------------

// File: rtl/muxn_pkg.sv
// Shared definitions for the N-channel registered mux: channel limits, mode
// encoding and the round-robin pointer wrap helper.
package muxn_pkg;

   localparam int NCH_MAX = 16;

   typedef enum logic {
      MODE_MANUAL = 1'b0,
      MODE_SCAN   = 1'b1
   } mode_e;

   // Advance a round-robin pointer by one, wrapping at nch.
   function automatic int unsigned rr_next(input int unsigned ptr, input int unsigned nch);
      return (ptr + 1 >= nch) ? 0 : ptr + 1;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requester found
// starting at ptr and wrapping modulo NCH.
module rr_arbiter #(
   parameter int NCH  = 4,
   parameter int SELW = $clog2(NCH)
) (
   input  logic [NCH-1:0]  req,
   input  logic [SELW-1:0] ptr,
   output logic [NCH-1:0]  grant,
   output logic [SELW-1:0] grant_idx,
   output logic            any
);

   function automatic int wrap(input int v);
      return (v >= NCH) ? v - NCH : v;
   endfunction

   // Walk the search order backwards so the closest requester to ptr wins last.
   always_comb begin
      grant     = '0;
      grant_idx = '0;
      any       = 1'b0;
      for (int k = NCH - 1; k >= 0; k--) begin
         if (req[wrap(int'(ptr) + k)]) begin
            grant                       = '0;
            grant[wrap(int'(ptr) + k)]  = 1'b1;
            grant_idx                   = SELW'(wrap(int'(ptr) + k));
            any                         = 1'b1;
         end
      end
   end

endmodule

// File: rtl/muxn_rr_reg.sv
// NCH-channel registered mux with manual or round-robin selection and a
// valid/ready output slot; each captured word carries its source channel.
module muxn_rr_reg
   import muxn_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int NCH   = 4,
   localparam int SELW = $clog2(NCH)
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 mode,
   input  logic [SELW-1:0]      sel,
   input  logic [NCH*WIDTH-1:0] d,
   input  logic [NCH-1:0]       d_valid,
   output logic [NCH-1:0]       d_ack,
   input  logic                 out_ready,
   output logic                 out_valid,
   output logic [WIDTH-1:0]     out_data,
   output logic [SELW-1:0]      out_ch,
   output logic                 sel_err
);

   logic [SELW-1:0] rr_ptr;
   logic [NCH-1:0]  arb_grant;
   logic [SELW-1:0] arb_idx;
   logic            arb_any;
   logic            mode_scan;
   logic            sel_ok;
   logic            man_grant;
   logic            grant_any;
   logic [SELW-1:0] g;
   logic            free;
   logic            cap;

   rr_arbiter #(.NCH(NCH), .SELW(SELW)) u_arb (
      .req       (d_valid),
      .ptr       (rr_ptr),
      .grant     (arb_grant),
      .grant_idx (arb_idx),
      .any       (arb_any)
   );

   assign mode_scan = (mode_e'(mode) == MODE_SCAN);
   assign sel_ok    = ({1'b0, sel} < (SELW+1)'(NCH));
   assign man_grant = sel_ok && d_valid[sel];
   assign grant_any = mode_scan ? arb_any : man_grant;
   assign g         = mode_scan ? arb_idx : sel;
   assign free      = !out_valid || out_ready;
   // Gated by rst_n so no ack leaks out while the slot is being cleared.
   assign cap       = rst_n && free && grant_any;
   assign d_ack     = cap ? (NCH'(1) << g) : '0;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_ch    <= '0;
         sel_err   <= 1'b0;
         rr_ptr    <= '0;
      end else begin
         if (!mode_scan && !sel_ok)
            sel_err <= 1'b1;
         if (cap) begin
            out_data  <= d[int'(g)*WIDTH +: WIDTH];
            out_ch    <= g;
            out_valid <= 1'b1;
            if (mode_scan)
               rr_ptr <= SELW'(rr_next(32'(arb_idx), NCH));
         end else if (free) begin
            out_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_muxn_rr_reg.sv
// Scoreboard bench for muxn_rr_reg: directed stimulus pushes expected words,
// a negedge monitor pops them on every output transfer.
module tb_muxn_rr_reg;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        mode;
   logic [1:0]  sel;
   logic [31:0] d;
   logic [3:0]  d_valid;
   logic [3:0]  d_ack;
   logic        out_ready;
   logic        out_valid;
   logic [7:0]  out_data;
   logic [1:0]  out_ch;
   logic        sel_err;

   logic        mode3;
   logic [1:0]  sel3;
   logic [23:0] d3;
   logic [2:0]  d_valid3;
   logic [2:0]  d_ack3;
   logic        out_ready3;
   logic        out_valid3;
   logic [7:0]  out_data3;
   logic [1:0]  out_ch3;
   logic        sel_err3;

   typedef struct {
      logic [7:0] data;
      logic [1:0] ch;
   } exp_t;

   exp_t q[$];
   int   total = 0;
   int   bad   = 0;

   always #5 clk = ~clk;

   muxn_rr_reg #(.WIDTH(8), .NCH(4)) dut (
      .clk(clk), .rst_n(rst_n), .mode(mode), .sel(sel), .d(d), .d_valid(d_valid),
      .d_ack(d_ack), .out_ready(out_ready), .out_valid(out_valid),
      .out_data(out_data), .out_ch(out_ch), .sel_err(sel_err)
   );

   muxn_rr_reg #(.WIDTH(8), .NCH(3)) dut3 (
      .clk(clk), .rst_n(rst_n), .mode(mode3), .sel(sel3), .d(d3), .d_valid(d_valid3),
      .d_ack(d_ack3), .out_ready(out_ready3), .out_valid(out_valid3),
      .out_data(out_data3), .out_ch(out_ch3), .sel_err(sel_err3)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   task automatic push(input logic [7:0] data, input logic [1:0] ch);
      exp_t e;
      e.data = data;
      e.ch   = ch;
      q.push_back(e);
   endtask

   // Monitor: every accepted output word must match the head of the queue.
   always @(negedge clk) begin
      if (rst_n && out_valid && out_ready) begin
         if (q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL mon_unexpected: got ch=%0d data=%0h want none", out_ch, out_data);
         end else begin
            exp_t e;
            e = q.pop_front();
            chk("mon_data", 32'(out_data), 32'(e.data));
            chk("mon_ch", 32'(out_ch), 32'(e.ch));
         end
      end
   end

   initial begin
      rst_n = 1'b0; mode = 1'b0; sel = '0; d = '0; d_valid = '0; out_ready = 1'b1;
      mode3 = 1'b0; sel3 = '0; d3 = '0; d_valid3 = '0; out_ready3 = 1'b1;

      // reset and idle
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_valid", 32'(out_valid), 0);
      chk("rst_data", 32'(out_data), 0);
      chk("rst_ch", 32'(out_ch), 0);
      chk("rst_ack", 32'(d_ack), 0);
      chk("rst_selerr", 32'(sel_err), 0);
      @(posedge clk); #1 rst_n = 1'b1;
      repeat (5) begin
         @(negedge clk);
         chk("idle_valid", 32'(out_valid), 0);
         chk("idle_ack", 32'(d_ack), 0);
      end

      // manual select of channel 2
      @(posedge clk); #1;
      mode = 1'b0; sel = 2'd2; d = '0; d[23:16] = 8'hA5; d_valid = 4'b0100;
      @(negedge clk);
      chk("man_ack", 32'(d_ack), 32'h4);
      push(8'hA5, 2'd2);
      @(posedge clk); #1 d_valid = '0;
      @(negedge clk);
      chk("man_valid", 32'(out_valid), 1);

      // round-robin fairness with all channels requesting
      @(posedge clk); #1;
      mode = 1'b1;
      for (int i = 0; i < 4; i++) d[i*8 +: 8] = 8'h10 + 8'(i);
      d_valid = 4'b1111;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         chk("rr_ack", 32'(d_ack), 32'(1) << (k % 4));
         push(8'h10 + 8'(k % 4), 2'(k % 4));
         @(posedge clk); #1;
      end
      d_valid = '0;
      @(negedge clk);
      chk("rr_idle_ack", 32'(d_ack), 0);

      // backpressure: 3C held in slot while channel 1 waits
      @(posedge clk); #1;
      mode = 1'b0; sel = 2'd3; d[31:24] = 8'h3C; d_valid = 4'b1000; out_ready = 1'b0;
      @(negedge clk);
      chk("bp_load_ack", 32'(d_ack), 32'h8);
      push(8'h3C, 2'd3);
      @(posedge clk); #1;
      sel = 2'd1; d[15:8] = 8'h77; d_valid = 4'b0010;
      repeat (4) begin
         @(negedge clk);
         chk("bp_data", 32'(out_data), 32'h3C);
         chk("bp_ch", 32'(out_ch), 3);
         chk("bp_valid", 32'(out_valid), 1);
         chk("bp_ack", 32'(d_ack), 0);
      end
      @(posedge clk); #1 out_ready = 1'b1;
      @(negedge clk);
      chk("bp_release_ack", 32'(d_ack), 32'h2);
      push(8'h77, 2'd1);
      @(posedge clk); #1 d_valid = '0;
      @(negedge clk);

      // reset mid-transfer; pointer must return to 0
      @(posedge clk); #1;
      mode = 1'b1; d_valid = 4'b0100; out_ready = 1'b0;
      @(negedge clk);
      chk("mid_ack", 32'(d_ack), 32'h4);
      @(posedge clk); #1 d_valid = 4'b1111;
      @(negedge clk);
      chk("mid_hold_valid", 32'(out_valid), 1);
      chk("mid_hold_ack", 32'(d_ack), 0);
      #2 rst_n = 1'b0;
      #1;
      chk("mid_async_valid", 32'(out_valid), 0);
      chk("mid_rst_ack", 32'(d_ack), 0);
      rst_n = 1'b1; out_ready = 1'b1;
      #1;
      chk("mid_ptr0_ack", 32'(d_ack), 32'h1);
      push(8'h10, 2'd0);
      @(posedge clk); #1 d_valid = '0;
      @(negedge clk);

      // invalid manual select on a 3-channel instance
      @(posedge clk); #1;
      sel3 = 2'd3; d3 = {8'h33, 8'h22, 8'h11}; d_valid3 = 3'b111;
      @(negedge clk);
      chk("inv_ack0", 32'(d_ack3), 0);
      @(posedge clk); #1;
      @(negedge clk);
      chk("inv_ack1", 32'(d_ack3), 0);
      chk("inv_valid", 32'(out_valid3), 0);
      chk("inv_selerr", 32'(sel_err3), 1);
      @(posedge clk); #1 sel3 = 2'd0;
      @(negedge clk);
      chk("inv_sel0_ack", 32'(d_ack3), 32'h1);
      chk("inv_sticky", 32'(sel_err3), 1);
      @(posedge clk); #1 d_valid3 = '0;
      @(negedge clk);
      chk("inv_cap_valid", 32'(out_valid3), 1);
      chk("inv_cap_data", 32'(out_data3), 32'h11);
      chk("inv_cap_ch", 32'(out_ch3), 0);
      chk("inv_sticky2", 32'(sel_err3), 1);
      chk("n4_selerr", 32'(sel_err), 0);

      repeat (2) @(negedge clk);
      chk("sb_empty", 32'(q.size()), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
